stream_pattern_gen: RTL and testbench
=====================================

// Module: stream_pattern_gen
// PURPOSE
//  AXI4-Stream test-pattern transmitter: the source end for stream_compare. Emits counter, PRBS31 or constant words
//  on a master port under TREADY backpressure, with optional burst length, TLAST and single-bit error injection.
//  Two instances with equal config feed both stream_compare inputs; inject_err on one exercises its mismatch/err_count.
// PARAMETERS
//  TDATA_WIDTH  32  data width in bits (>=8, multiple of 8)
//  COUNT_WIDTH  32  width of length and word_count
// PORTS
//  clk            in   1            single clock; all logic on posedge
//  reset          in   1            asynchronous, active-high reset
//  start          in   1            pulse: begin a burst (ignored while busy)
//  stop           in   1            pulse: end burst after the beat in flight completes
//  mode           in   2            0 counter, 1 PRBS31, 2 constant (=seed), 3 treated as counter
//  seed           in   TDATA_WIDTH  counter start / PRBS seed / constant value
//  length         in   COUNT_WIDTH  words per burst; 0 = unbounded (until stop)
//  inject_err     in   1            pulse: invert bit 0 of the next new word loaded
//  M_AXIS_TDATA   out  TDATA_WIDTH  stream data
//  M_AXIS_TVALID  out  1            stream valid
//  M_AXIS_TREADY  in   1            stream ready
//  M_AXIS_TLAST   out  1            final word of a bounded burst
//  busy           out  1            high in RUN
//  done           out  1            1-cycle pulse when a burst ends (length reached or stop)
//  word_count     out  COUNT_WIDTH  beats accepted this burst; cleared on start
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, FSM IDLE, PRBS state all-ones, inject pending cleared.
//  - FSM IDLE -> RUN on start; mode/seed/length sampled into config regs that cycle. RUN -> IDLE after the
//    handshake of the final beat or after stop takes effect; done pulses the cycle after.
//  - Latency: start at cycle N -> TVALID=1 with word 0 at N+1. No bubbles while TREADY=1 (1 word/clk).
//  - AXI rules: once TVALID=1, TDATA/TLAST held stable until TVALID&TREADY; TVALID never drops without handshake.
//  - Beat k (k from 0): counter = seed + k mod 2^TDATA_WIDTH; constant = seed; PRBS31 (x^31+x^28+1) advanced
//    TDATA_WIDTH steps per word, word = low TDATA_WIDTH bits of state after advance; seed 0 in PRBS -> all-ones.
//  - Next word computed on handshake only; a stalled beat does not advance the generator.
//  - TLAST=1 only on beat length-1 when length!=0; length=1 -> single beat with TLAST. Unbounded: TLAST=0 always.
//  - stop in RUN: pending flag; if TVALID low or handshake this cycle -> IDLE next cycle, else finish current beat
//    then IDLE. TLAST not asserted on stopped bursts. stop in IDLE ignored. start+stop same cycle in IDLE: start wins,
//    stop ignored.
//  - inject_err: sets pending flag; applied (bit 0 XOR 1) to the next word loaded into TDATA, then cleared; does not
//    alter generator state (next word is clean). Pending survives across bursts; cleared only by reset or use.
//  - word_count increments on each handshake, saturates at all-ones; holds after burst until next start.
//  - start while busy ignored; mode/seed/length changes mid-burst have no effect.
// STRUCTURE
//  - Package stream_pattern_pkg: typedef enum {MODE_COUNTER, MODE_PRBS31, MODE_CONST} mode_t; FSM state_t
//    {IDLE, RUN}; PRBS31 tap constants; function prbs31_advance(state, nsteps).
//  - One sub-module: prbs31_step (combinational, TDATA_WIDTH-step parallel LFSR advance).
//  - Main block: FSM + config regs + output register stage in one always_ff / always_comb pair.
// TESTING
//  - mode=0, seed=0x10, length=4, TREADY=1: words 0x10..0x13 on 4 consecutive cycles, TLAST on 0x13, done next clk.
//  - Same, TREADY toggling 1/0: identical word sequence, TDATA stable during stalls, word_count=4 at end.
//  - mode=1, seed=0: first words match PRBS31 reference model from all-ones; two instances fed to stream_compare
//    -> err_count=0 over 10000 words.
//  - inject_err on one instance mid-stream -> exactly one word differs in bit 0; stream_compare err_count=1.
//  - length=0, stop asserted while TVALID=1/TREADY=0 -> beat completes on TREADY, then TVALID=0, TLAST never set.
//  - reset asserted mid-burst (async, between edges) -> TVALID/busy/word_count 0 immediately; new start restarts at seed.

Source files
------------

// File: rtl/stream_pattern_pkg.sv
// Shared types and PRBS31 helpers for the stream pattern generator.
package stream_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_PRBS31  = 2'd1,
        MODE_CONST   = 2'd2
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // x^31 + x^28 + 1: feedback taps on state bits 30 and 27.
    localparam int unsigned PRBS_LEN   = 31;
    localparam int unsigned PRBS_TAP_A = 30;
    localparam int unsigned PRBS_TAP_B = 27;
    // Widest state the helper handles; bits above 31 just keep shift history.
    localparam int unsigned PRBS_MAX_W = 64;

    // Advance the shift register nsteps times, new bits entering at bit 0.
    function automatic logic [PRBS_MAX_W-1:0] prbs31_advance(
        input logic [PRBS_MAX_W-1:0] state,
        input int unsigned           nsteps
    );
        logic [PRBS_MAX_W-1:0] s;
        s = state;
        for (int unsigned i = 0; i < nsteps; i++) begin
            s = {s[PRBS_MAX_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
        end
        return s;
    endfunction

endpackage

// File: rtl/stream_pattern_gen_if.sv
// AXI4-Stream bundle between a pattern source and its sink.
interface stream_pattern_gen_if #(
    parameter int unsigned TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_pattern_gen_prbs31_step.sv
// Combinational parallel PRBS31 advance by NSTEPS shifts.
module prbs31_step
    import stream_pattern_pkg::*;
#(
    parameter int unsigned STATE_WIDTH = 32,
    parameter int unsigned NSTEPS      = 32
) (
    input  logic [STATE_WIDTH-1:0] state_in,
    output logic [STATE_WIDTH-1:0] state_out
);

    // Unrolled shift network; upper helper bits beyond STATE_WIDTH are dropped.
    always_comb begin
        state_out = STATE_WIDTH'(prbs31_advance(PRBS_MAX_W'(state_in), NSTEPS));
    end

endmodule

// File: rtl/stream_pattern_gen.sv
// AXI4-Stream test-pattern source: counter, PRBS31 or constant words with
// optional burst length, TLAST, stop and single-bit error injection.
module stream_pattern_gen
    import stream_pattern_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [TDATA_WIDTH-1:0] seed,
    input  logic [COUNT_WIDTH-1:0] length,
    input  logic                   inject_err,
    stream_pattern_gen_if.master   m_axis,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] word_count
);

    // LFSR needs at least 31 bits; wider words extend it with shift history.
    localparam int unsigned SW = (TDATA_WIDTH > PRBS_LEN) ? TDATA_WIDTH : PRBS_LEN;

    state_t                 state_q, state_d;
    mode_t                  cfg_mode_q, cfg_mode_d;
    logic [TDATA_WIDTH-1:0] cfg_seed_q, cfg_seed_d;
    logic [COUNT_WIDTH-1:0] cfg_len_q, cfg_len_d;
    logic [COUNT_WIDTH-1:0] beat_q, beat_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TDATA_WIDTH-1:0] clean_q, clean_d;    // current word before injection
    logic [SW-1:0]          prbs_q, prbs_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   done_q, done_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   inj_pend_q, inj_pend_d;

    logic [SW-1:0]          prbs_init, step_in, step_out;
    logic [TDATA_WIDTH-1:0] word, inj_mask;
    logic [COUNT_WIDTH-1:0] beat_nxt;
    logic                   hs;

    // Seed with zero LFSR bits would lock up; substitute all-ones.
    always_comb begin
        prbs_init = SW'(seed);
        if (prbs_init[PRBS_LEN-1:0] == '0) begin
            prbs_init = '1;
        end
        step_in = (state_q == IDLE) ? prbs_init : prbs_q;
    end

    prbs31_step #(
        .STATE_WIDTH (SW),
        .NSTEPS      (TDATA_WIDTH)
    ) u_prbs31_step (
        .state_in  (step_in),
        .state_out (step_out)
    );

    // Next-state: burst FSM, config capture and output word loading.
    always_comb begin
        state_d     = state_q;
        cfg_mode_d  = cfg_mode_q;
        cfg_seed_d  = cfg_seed_q;
        cfg_len_d   = cfg_len_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        clean_d     = clean_q;
        prbs_d      = prbs_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        inj_pend_d  = inj_pend_q | inject_err;
        word        = clean_q;
        inj_mask    = {{(TDATA_WIDTH-1){1'b0}}, inj_pend_q | inject_err};
        hs          = tvalid_q & m_axis.tready;
        beat_nxt    = beat_q + COUNT_WIDTH'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (mode)
                        MODE_PRBS31: begin
                            cfg_mode_d = MODE_PRBS31;
                            word       = step_out[TDATA_WIDTH-1:0];
                            prbs_d     = step_out;
                        end
                        MODE_CONST: begin
                            cfg_mode_d = MODE_CONST;
                            word       = seed;
                        end
                        default: begin
                            cfg_mode_d = MODE_COUNTER;
                            word       = seed;
                        end
                    endcase
                    cfg_seed_d  = seed;
                    cfg_len_d   = length;
                    beat_d      = '0;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                    clean_d     = word;
                    tdata_d     = word ^ inj_mask;
                    inj_pend_d  = 1'b0;
                    tvalid_d    = 1'b1;
                    tlast_d     = (length == COUNT_WIDTH'(1));
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + COUNT_WIDTH'(1);
                    end
                    if (tlast_q || stop_pend_q || stop) begin
                        state_d     = IDLE;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        unique case (cfg_mode_q)
                            MODE_PRBS31: begin
                                word   = step_out[TDATA_WIDTH-1:0];
                                prbs_d = step_out;
                            end
                            MODE_CONST: word = cfg_seed_q;
                            default:    word = clean_q + TDATA_WIDTH'(1);
                        endcase
                        beat_d     = beat_nxt;
                        clean_d    = word;
                        tdata_d    = word ^ inj_mask;
                        inj_pend_d = 1'b0;
                        tlast_d    = (cfg_len_q != '0) &&
                                     (beat_nxt == cfg_len_q - COUNT_WIDTH'(1));
                    end
                end else if (stop) begin
                    // Beat in flight must still complete before leaving RUN.
                    stop_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cfg_mode_q  <= MODE_COUNTER;
            cfg_seed_q  <= '0;
            cfg_len_q   <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            clean_q     <= '0;
            prbs_q      <= '1;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            inj_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_seed_q  <= cfg_seed_d;
            cfg_len_q   <= cfg_len_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            clean_q     <= clean_d;
            prbs_q      <= prbs_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            inj_pend_q  <= inj_pend_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign word_count    = cnt_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed-vector bench for stream_pattern_gen.
module tb_stream_pattern_gen;

    localparam int TW = 32;
    localparam int CW = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          inject_err = 1'b0;
    logic [1:0]    mode       = 2'd0;
    logic [TW-1:0] seed       = '0;
    logic [CW-1:0] length     = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_count;

    int vectors     = 0;
    int miscompares = 0;

    stream_pattern_gen_if #(.TDATA_WIDTH(TW)) axis ();

    stream_pattern_gen #(
        .TDATA_WIDTH (TW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .seed       (seed),
        .length     (length),
        .inject_err (inject_err),
        .m_axis     (axis),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then scramble the config inputs to prove they were captured.
    task automatic start_burst(input logic [1:0] m, input logic [TW-1:0] s, input logic [CW-1:0] l);
        mode   = m;
        seed   = s;
        length = l;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        mode   = 2'd2;
        seed   = ~s;
        length = 32'd5;
    endtask

    // Bit-serial PRBS31 reference: 32 shifts of x^31+x^28+1 per word.
    function automatic logic [31:0] ref_prbs(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 32; i++) r = {r[30:0], r[30] ^ r[27]};
        return r;
    endfunction

    task automatic test_reset();
        vectors++;
        if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
        vectors++;
        if (axis.tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata got %h want 0", axis.tdata); end
        vectors++;
        if ({busy, done, axis.tlast} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got %b want 000", {busy, done, axis.tlast});
        end
        vectors++;
        if (word_count !== 32'h0) begin miscompares++; $display("FAIL reset_count got %0d want 0", word_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_counter();
        axis.tready = 1'b1;
        start_burst(2'd0, 32'h10, 32'd4);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h10 + k) begin
                miscompares++; $display("FAIL cnt_word%0d got %b/%h want 1/%h", k, axis.tvalid, axis.tdata, 32'h10 + k);
            end
            vectors++;
            if (axis.tlast !== (k == 3)) begin miscompares++; $display("FAIL cnt_tlast%0d got %b", k, axis.tlast); end
            tick();
        end
        vectors++;
        if ({done, busy, axis.tvalid} !== 3'b100) begin
            miscompares++; $display("FAIL cnt_end got done/busy/valid %b want 100", {done, busy, axis.tvalid});
        end
        vectors++;
        if (word_count !== 32'd4) begin miscompares++; $display("FAIL cnt_count got %0d want 4", word_count); end
        tick();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL cnt_done_pulse got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        int   idx;
        logic hs;
        idx = 0;
        start_burst(2'd0, 32'h10, 32'd4);
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            axis.tready = cyc[0];
            vectors++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h10 + idx || axis.tlast !== (idx == 3)) begin
                miscompares++;
                $display("FAIL bp_beat%0d got v=%b d=%h l=%b want v=1 d=%h", idx, axis.tvalid, axis.tdata,
                         axis.tlast, 32'h10 + idx);
            end
            hs = axis.tready;
            tick();
            if (hs) idx++;
        end
        vectors++;
        if (idx != 4) begin miscompares++; $display("FAIL bp_timeout got %0d beats want 4", idx); end
        vectors++;
        if (word_count !== 32'd4 || done !== 1'b1) begin
            miscompares++; $display("FAIL bp_end got count=%0d done=%b want 4/1", word_count, done);
        end
        axis.tready = 1'b1;
        tick();
    endtask

    task automatic test_prbs();
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        start_burst(2'd1, 32'h0, 32'd0);
        for (int k = 0; k < 7; k++) begin
            m = ref_prbs(m);
            if (k == 6) stop = 1'b1;
            vectors++;
            if (axis.tdata !== m || axis.tlast !== 1'b0) begin
                miscompares++; $display("FAIL prbs_word%0d got %h/%b want %h/0", k, axis.tdata, axis.tlast, m);
            end
            tick();
        end
        stop = 1'b0;
        vectors++;
        if ({done, axis.tvalid} !== 2'b10 || word_count !== 32'd7) begin
            miscompares++; $display("FAIL prbs_stop got done/valid=%b count=%0d want 10/7", {done, axis.tvalid},
                                    word_count);
        end
        tick();
        m = 32'h1234_5678;
        start_burst(2'd1, 32'h1234_5678, 32'd2);
        for (int k = 0; k < 2; k++) begin
            m = ref_prbs(m);
            vectors++;
            if (axis.tdata !== m || axis.tlast !== (k == 1)) begin
                miscompares++; $display("FAIL prbs_seed_word%0d got %h/%b want %h", k, axis.tdata, axis.tlast, m);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_const_and_bounds();
        start_burst(2'd2, 32'hA5A5_0003, 32'd3);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (axis.tdata !== 32'hA5A5_0003 || axis.tlast !== (k == 2)) begin
                miscompares++; $display("FAIL const_word%0d got %h/%b want a5a50003", k, axis.tdata, axis.tlast);
            end
            tick();
        end
        tick();
        // Mode 3 behaves as counter; counter wraps modulo 2^32.
        start_burst(2'd3, 32'hFFFF_FFFF, 32'd2);
        vectors++;
        if (axis.tdata !== 32'hFFFF_FFFF || axis.tlast !== 1'b0) begin
            miscompares++; $display("FAIL wrap_word0 got %h/%b want ffffffff/0", axis.tdata, axis.tlast);
        end
        tick();
        vectors++;
        if (axis.tdata !== 32'h0 || axis.tlast !== 1'b1) begin
            miscompares++; $display("FAIL wrap_word1 got %h/%b want 0/1", axis.tdata, axis.tlast);
        end
        tick();
        tick();
        start_burst(2'd0, 32'h7, 32'd1);
        vectors++;
        if (axis.tdata !== 32'h7 || axis.tlast !== 1'b1) begin
            miscompares++; $display("FAIL len1_word got %h/%b want 7/1", axis.tdata, axis.tlast);
        end
        tick();
        vectors++;
        if ({done, busy, axis.tvalid} !== 3'b100 || word_count !== 32'd1) begin
            miscompares++; $display("FAIL len1_end got %b count=%0d want 100/1", {done, busy, axis.tvalid}, word_count);
        end
        tick();
    endtask

    task automatic test_inject();
        logic [31:0] exp_w [4];
        exp_w = '{32'h100, 32'h100, 32'h102, 32'h103};
        axis.tready = 1'b0;
        start_burst(2'd0, 32'h100, 32'd0);
        inject_err = 1'b1;
        tick();
        inject_err  = 1'b0;
        axis.tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stop = 1'b1;
            vectors++;
            if (axis.tdata !== exp_w[k]) begin
                miscompares++; $display("FAIL inj_word%0d got %h want %h", k, axis.tdata, exp_w[k]);
            end
            tick();
        end
        stop = 1'b0;
        vectors++;
        if (axis.tvalid !== 1'b0 || word_count !== 32'd4) begin
            miscompares++; $display("FAIL inj_stop got valid=%b count=%0d want 0/4", axis.tvalid, word_count);
        end
        // Pending flag set in IDLE carries into the next burst.
        inject_err = 1'b1;
        tick();
        inject_err = 1'b0;
        start_burst(2'd0, 32'h200, 32'd2);
        vectors++;
        if (axis.tdata !== 32'h201) begin miscompares++; $display("FAIL inj_carry0 got %h want 201", axis.tdata); end
        tick();
        vectors++;
        if (axis.tdata !== 32'h201 || axis.tlast !== 1'b1) begin
            miscompares++; $display("FAIL inj_carry1 got %h/%b want 201/1", axis.tdata, axis.tlast);
        end
        tick();
        tick();
    endtask

    task automatic test_stop_stalled();
        axis.tready = 1'b1;
        stop        = 1'b1;
        start_burst(2'd0, 32'h20, 32'd0);
        stop  = 1'b0;
        start = 1'b1;
        seed  = 32'h99;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || axis.tdata !== 32'h21) begin
            miscompares++; $display("FAIL ss_start_wins got busy=%b d=%h want 1/21", busy, axis.tdata);
        end
        axis.tready = 1'b0;
        stop        = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({axis.tvalid, axis.tlast, busy} !== 3'b101 || axis.tdata !== 32'h21) begin
                miscompares++; $display("FAIL ss_hold%0d got v/l/b=%b d=%h want 101/21", k,
                                        {axis.tvalid, axis.tlast, busy}, axis.tdata);
            end
            tick();
        end
        axis.tready = 1'b1;
        tick();
        vectors++;
        if ({axis.tvalid, axis.tlast, done} !== 3'b001 || word_count !== 32'd2) begin
            miscompares++; $display("FAIL ss_end got v/l/done=%b count=%0d want 001/2",
                                    {axis.tvalid, axis.tlast, done}, word_count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_burst(2'd0, 32'h40, 32'd0);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({axis.tvalid, busy} !== 2'b00 || word_count !== 32'h0) begin
            miscompares++; $display("FAIL rst_mid got v/b=%b count=%0d want 00/0", {axis.tvalid, busy}, word_count);
        end
        reset = 1'b0;
        tick();
        start_burst(2'd0, 32'h40, 32'd0);
        vectors++;
        if (axis.tdata !== 32'h40 || word_count !== 32'h0) begin
            miscompares++; $display("FAIL rst_restart got %h count=%0d want 40/0", axis.tdata, word_count);
        end
    endtask

    initial begin
        axis.tready = 1'b0;
        tick();
        tick();
        test_reset();
        test_counter();
        test_backpressure();
        test_prbs();
        test_const_and_bounds();
        test_inject();
        test_stop_stalled();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
